// File: rtl/adc_spi_responder.sv
// adc_spi_responder: slave-side model of an 8-channel 12-bit serial ADC, oversampled on clk
module adc_spi_responder #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [2:0] RESET_ADDR  = 3'b000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cs_n,
    input  logic        sclk,
    input  logic        din,
    input  logic [95:0] ch_data,
    output logic        dout,
    output logic        dout_oe,
    output logic [2:0]  cur_addr,
    output logic        frame_done,
    output logic        frame_abort
);
    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, sclk_sync_q, din_sync_q, warm_q;
    logic                   sclk_prev_q, armed_q;
    logic                   skip_q, skip_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic [15:0]            shreg_q, shreg_d;
    logic [2:0]             addr_next_q, addr_next_d, cur_addr_q, cur_addr_d;
    logic                   frame_done_q, frame_done_d, frame_abort_q, frame_abort_d;
    logic                   cs_s, sclk_s, din_s, sclk_rise, sclk_fall, cs_fall, last_edge;
    logic [11:0]            ch [8];

    for (genvar k = 0; k < 8; k++) begin : g_ch
        assign ch[k] = ch_data[12*k +: 12];
    end

    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign din_s     = din_sync_q[SYNC_STAGES-1];
    assign sclk_rise = ~sclk_prev_q & sclk_s;
    assign sclk_fall = sclk_prev_q & ~sclk_s;
    // armed_q only reflects a real high cs_n sample once the chain holds post-reset data,
    // so a cs_n already low at reset release cannot start a frame
    assign cs_fall   = armed_q & ~cs_s;
    assign last_edge = sclk_rise && (bit_cnt_q == 4'd15);

    assign dout        = (state_q == ACTIVE) & shreg_q[15];
    assign dout_oe     = (state_q == ACTIVE);
    assign cur_addr    = cur_addr_q;
    assign frame_done  = frame_done_q;
    assign frame_abort = frame_abort_q;

    // Input synchronizers, sclk edge history and the cs_n arming flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_sync_q   <= '1;
            sclk_sync_q <= '1;
            din_sync_q  <= '1;
            warm_q      <= '0;
            sclk_prev_q <= 1'b1;
            armed_q     <= 1'b0;
        end else begin
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            din_sync_q  <= {din_sync_q[SYNC_STAGES-2:0], din};
            warm_q      <= {warm_q[SYNC_STAGES-2:0], 1'b1};
            sclk_prev_q <= sclk_s;
            armed_q     <= warm_q[SYNC_STAGES-1] & cs_s;
        end
    end

    // Frame state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            skip_q        <= 1'b0;
            bit_cnt_q     <= '0;
            shreg_q       <= '0;
            addr_next_q   <= RESET_ADDR;
            cur_addr_q    <= RESET_ADDR;
            frame_done_q  <= 1'b0;
            frame_abort_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            skip_q        <= skip_d;
            bit_cnt_q     <= bit_cnt_d;
            shreg_q       <= shreg_d;
            addr_next_q   <= addr_next_d;
            cur_addr_q    <= cur_addr_d;
            frame_done_q  <= frame_done_d;
            frame_abort_q <= frame_abort_d;
        end
    end

    // Next state: the first sclk fall of each frame is skipped because bit 1 is already on dout
    always_comb begin
        state_d       = state_q;
        skip_d        = skip_q;
        bit_cnt_d     = bit_cnt_q;
        shreg_d       = shreg_q;
        addr_next_d   = addr_next_q;
        cur_addr_d    = cur_addr_q;
        frame_done_d  = 1'b0;
        frame_abort_d = 1'b0;
        if (state_q == IDLE) begin
            bit_cnt_d = '0;
            if (cs_fall) begin
                state_d = ACTIVE;
                shreg_d = {4'b0000, ch[cur_addr_q]};
                skip_d  = 1'b1;
            end
        end else begin
            if (sclk_fall) begin
                skip_d  = 1'b0;
                shreg_d = skip_q ? shreg_q : {shreg_q[14:0], 1'b0};
            end
            if (sclk_rise) begin
                bit_cnt_d = bit_cnt_q + 4'd1;
                if (bit_cnt_q >= 4'd2 && bit_cnt_q <= 4'd4) addr_next_d = {addr_next_q[1:0], din_s};
                if (last_edge) begin
                    cur_addr_d   = addr_next_q;
                    frame_done_d = 1'b1;
                    shreg_d      = {4'b0000, ch[addr_next_q]};
                    skip_d       = 1'b1;
                end
            end
            if (cs_s) begin
                state_d       = IDLE;
                bit_cnt_d     = '0;
                frame_abort_d = !last_edge && (bit_cnt_q != 4'd0 || sclk_rise);
                if (frame_abort_d) addr_next_d = cur_addr_q;
            end
        end
    end
endmodule

// File: doc/adc_spi_responder.md
# adc_spi_responder

- Slave-side model of the 8-channel, 12-bit serial ADC that our SPI interface master drives.
- Oversamples the master's `cs_n`, `sclk` and `saddr` with the system clock.
- Captures the 3-bit channel address from the input stream and shifts back 16-bit frames: 4 leading zeros, then 12 data bits MSB first.
- Used as a synthesizable loopback target on the FPGA and as the bench model for the master.

## Interface

Parameters:
- `SYNC_STAGES`, default 2: synchronizer depth on `cs_n`, `sclk`, `din`. Legal range 2–3.
- `RESET_ADDR`, default 3'b000: channel converted in the first frame after reset.

Ports:
- `clk`  in  1: system clock. Must be ≥ 8× the SCLK frequency.
- `rst_n`  in  1: asynchronous, active-low reset.
- `cs_n`  in  1: chip select from the master, active low.
- `sclk`  in  1: serial clock from the master. Idles high.
- `din`  in  1: address bit stream from the master (the master's `saddr`).
- `ch_data`  in  96: channel values. Channel k occupies bits [12k+11:12k].
- `dout`  out  1: serial data to the master.
- `dout_oe`  out  1: output enable for `dout`. High while the frame is selected.
- `cur_addr`  out  3: address of the channel converted in the current or next frame.
- `frame_done`  out  1: one-`clk` pulse after the 16th SCLK rising edge.
- `frame_abort`  out  1: one-`clk` pulse when `cs_n` rises with 1–15 rising edges counted.

## Operation

Input conditioning:
- `cs_n`, `sclk` and `din` each pass through a `SYNC_STAGES` flop chain.
- Edge detect compares the last two synchronized `sclk` samples.
- All logic runs on `clk` only. SCLK is never used as a clock.

State machine:
- IDLE:
  - `dout_oe`=0, `dout`=0, edge counter `bit_cnt`=0.
  - Synchronized `cs_n` falling → ACTIVE. On entry, latch `shreg` = {4'b0000, ch_data[cur_addr]}.
- ACTIVE, bit index n = `bit_cnt`+1, n = 1..16:
  - `dout_oe`=1 and `dout` = `shreg[15]`.
  - On each detected SCLK falling edge except the first after CS, `shreg` shifts left by one. Bit n is therefore stable across SCLK rising edge n.
  - On SCLK rising edge n: `bit_cnt` increments. If n ∈ {3,4,5}, `din` shifts into `addr_next` (order ADD2, ADD1, ADD0).
  - On rising edge 16:
    - `cur_addr` ← `addr_next`; `frame_done` pulses; `bit_cnt` ← 0.
    - `shreg` reloads with {4'b0000, ch_data[new cur_addr]}. This is continuous mode: a new frame starts without CS toggling.
  - Synchronized `cs_n` rising → IDLE.
    - If 1 ≤ `bit_cnt` ≤ 15: pulse `frame_abort`, leave `cur_addr` unchanged, discard `addr_next`.
    - If `bit_cnt` = 0: no pulse.
- Address takes effect one frame late. Frame N converts the address received in frame N−1. The first frame after reset converts `RESET_ADDR`.
- `ch_data` is sampled only at frame start or reload. Changes mid-frame do not alter bits already in `shreg`.

## Timing

- Reset values:
  - `dout`=0, `dout_oe`=0, `frame_done`=0, `frame_abort`=0.
  - `cur_addr`=`RESET_ADDR`, `addr_next`=`RESET_ADDR`, state IDLE, `bit_cnt`=0.
  - All synchronizer flops reset to 1, matching the idle level of `cs_n`/`sclk`; `din` synchronizer flops also reset to 1.
- Latency: `dout` updates at most SYNC_STAGES+1 `clk` cycles after the SCLK falling edge or CS falling edge. This holds setup at the master's sampling edge when `clk` ≥ 8×SCLK.
- `frame_done` and `frame_abort` are asserted exactly one `clk` cycle, SYNC_STAGES+1 cycles after the triggering pin edge.
- Simultaneous events:
  - CS rise detected in the same `clk` cycle as SCLK rising edge 16: the frame counts as complete. `frame_done` pulses, no abort, then IDLE.
  - SCLK edges while synchronized `cs_n`=1 are ignored.
- Reset asserted mid-frame: all outputs return to reset values immediately, with no pulse. After release, the block waits for a fresh `cs_n` fall. If `cs_n` is already low at release, it waits for `cs_n` to go high, then low.

## Test plan

- Reset, `ch_data` channel 0 = 12'hABC. One 16-clock frame with address 3'b101. Expected:
  - `dout` bits = 0000_1010_1011_1100.
  - `frame_done` pulses once.
  - `cur_addr` = 5.
- Second frame with channel 5 = 12'h123 and address 3'b010. Expected: `dout` = 0000_0001_0010_0011, `cur_addr` = 2.
- Abort: raise `cs_n` after 9 SCLK rising edges, with address 3'b111 sent. Expected: `frame_abort` pulse, `cur_addr` unchanged, `dout_oe` = 0 within SYNC_STAGES+1 cycles.
- Continuous mode: 32 SCLK periods with one CS low, addresses 3'b011 then 3'b100. Expected:
  - Two `frame_done` pulses.
  - The second frame's data comes from channel 3.
  - `cur_addr` ends at 4.
- Change `ch_data` mid-frame after bit 6. Expected: the shifted word keeps the value latched at frame start.
- Assert `rst_n` at bit 10, release with `cs_n` low. Expected:
  - `dout_oe` stays 0 until `cs_n` cycles high then low.
  - The next frame converts `RESET_ADDR`.
